// File: rtl/march_bist.sv
// March C- / MATS+ memory BIST controller with a functional bypass path.
// While idle the SRAM port follows the functional port. A run walks the
// selected march algorithm one operation per cycle, compares each read one
// cycle later and records the first failure plus a saturating failure count.
module march_bist #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              stop_on_fail,
    input  logic [DATA_W-1:0] bg,
    input  logic              func_we,
    input  logic [ADDR_W-1:0] func_addr,
    input  logic [DATA_W-1:0] func_wdata,
    output logic [DATA_W-1:0] func_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_syn,
    output logic [CNT_W-1:0]  fail_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nx;

    // Latched run configuration
    logic              mode_q, sof_q;
    logic [DATA_W-1:0] bg_q;

    // March position: element, address, operation within the element
    logic [2:0]        elem_q;
    logic [ADDR_W-1:0] addr_q;
    logic              op_q;

    // Read pipeline: expectation registered with the read, checked next cycle
    logic              rd_vld;
    logic [DATA_W-1:0] rd_exp;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_elem;

    logic              fail_q;
    logic [CNT_W-1:0]  cnt_q;

    // Element decode
    logic       el_two, el_rv, el_rd1, el_down;
    logic [2:0] last_elem;
    logic       op_rd, op_val, last_op, addr_end, run_end, miscmp, stop;
    logic [DATA_W-1:0] op_data;

    // Down-counting elements: C- elements 3,4; MATS+ element 2
    function automatic logic is_down(input logic m, input logic [2:0] e);
        return m ? (e == 3'd2) : (e == 3'd3 || e == 3'd4);
    endfunction

    // Decode the current element into op count, first-op value and kind.
    // Two-op elements are always (rV, w~V); single-op elements are w0 or r0.
    always_comb begin
        el_two    = 1'b0;
        el_rv     = 1'b0;
        el_rd1    = 1'b0;
        last_elem = mode_q ? 3'd2 : 3'd5;
        if (!mode_q) begin
            case (elem_q)
                3'd1, 3'd3: el_two = 1'b1;
                3'd2, 3'd4: begin el_two = 1'b1; el_rv = 1'b1; end
                3'd5:       el_rd1 = 1'b1;
                default:    ;
            endcase
        end else begin
            case (elem_q)
                3'd1:    el_two = 1'b1;
                3'd2:    begin el_two = 1'b1; el_rv = 1'b1; end
                default: ;
            endcase
        end
        el_down  = is_down(mode_q, elem_q);
        op_rd    = el_two ? !op_q : el_rd1;
        op_val   = el_two ? (op_q ? !el_rv : el_rv) : 1'b0;
        op_data  = op_val ? ~bg_q : bg_q;
        last_op  = !el_two || op_q;
        addr_end = el_down ? (addr_q == '0) : (addr_q == '1);
        run_end  = last_op && addr_end && (elem_q == last_elem);
        miscmp   = rd_vld && (mem_rdata != rd_exp);
        stop     = miscmp && sof_q;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (stop || run_end) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_DONE;
            S_DONE:  if (!start) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Configuration latch and march position counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 1'b0;
            sof_q  <= 1'b0;
            bg_q   <= '0;
            elem_q <= '0;
            addr_q <= '0;
            op_q   <= 1'b0;
        end else if (state == S_IDLE && start) begin
            mode_q <= mode;
            sof_q  <= stop_on_fail;
            bg_q   <= bg;
            elem_q <= '0;
            addr_q <= '0;
            op_q   <= 1'b0;
        end else if (state == S_RUN && !stop && !run_end) begin
            if (!last_op) begin
                op_q <= 1'b1;
            end else begin
                op_q <= 1'b0;
                if (addr_end) begin
                    elem_q <= elem_q + 3'd1;
                    addr_q <= is_down(mode_q, elem_q + 3'd1) ? '1 : '0;
                end else if (el_down) begin
                    addr_q <= addr_q - ADDR_W'(1);
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

    // Read pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld  <= 1'b0;
            rd_exp  <= '0;
            rd_addr <= '0;
            rd_elem <= '0;
        end else begin
            rd_vld  <= (state == S_RUN) && op_rd;
            rd_exp  <= op_data;
            rd_addr <= addr_q;
            rd_elem <= elem_q;
        end
    end

    // Failure status: sticky flag, saturating count, first-failure capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_q    <= 1'b0;
            cnt_q     <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_syn  <= '0;
        end else if (state == S_IDLE && start) begin
            fail_q    <= 1'b0;
            cnt_q     <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_syn  <= '0;
        end else if (miscmp) begin
            fail_q <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            if (!fail_q) begin
                fail_addr <= rd_addr;
                fail_elem <= rd_elem;
                fail_syn  <= rd_exp ^ mem_rdata;
            end
        end
    end

    assign busy       = (state == S_RUN) || (state == S_DRAIN);
    assign done       = (state == S_DONE);
    assign pass       = done && !fail_q;
    assign fail       = fail_q;
    assign fail_cnt   = cnt_q;
    assign func_rdata = mem_rdata;

    // SRAM port mux: functional path whenever the BIST is not busy
    assign mem_we    = busy ? ((state == S_RUN) && !op_rd) : func_we;
    assign mem_addr  = busy ? addr_q  : func_addr;
    assign mem_wdata = busy ? op_data : func_wdata;

endmodule

// File: tb/tb_march_bist.sv
// Bench for march_bist: SRAM model with injectable stuck-at faults and a
// string-driven march reference model that predicts every op, the done
// cycle and the failure status.
module tb_march_bist;
    localparam int N = 256;

    logic       clk = 1'b0, rst = 1'b0;
    logic       start = 1'b0, mode = 1'b0, stop_on_fail = 1'b0;
    logic [3:0] bg = '0;
    logic       func_we = 1'b0;
    logic [7:0] func_addr = '0;
    logic [3:0] func_wdata = '0, func_rdata;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [3:0] mem_wdata, mem_rdata = '0;
    logic       busy, done, pass, fail;
    logic [7:0] fail_addr;
    logic [2:0] fail_elem;
    logic [3:0] fail_syn;
    logic [7:0] fail_cnt;

    int n_chk = 0, n_err = 0;

    march_bist dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .stop_on_fail(stop_on_fail), .bg(bg),
        .func_we(func_we), .func_addr(func_addr), .func_wdata(func_wdata),
        .func_rdata(func_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_syn(fail_syn),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    // SRAM with stuck-at faults applied on the read path
    logic [3:0] sram [0:N-1];
    int         fault_addr = -1;
    bit         fault_all = 1'b0;
    logic [3:0] s1 = '0, s0 = '0;

    function automatic logic [3:0] faulty(input int a, input logic [3:0] v);
        if (fault_all || a == fault_addr) return (v & ~s0) | s1;
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        mem_rdata <= faulty(int'(mem_addr), sram[mem_addr]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model outputs
    bit         e_we[$];
    int         e_addr[$];
    logic [3:0] e_data[$];
    int         e_cnt, e_faddr, e_felem, e_fsyn, n_ops;
    bit         e_fail;

    task automatic model(input bit m, input bit sof, input logic [3:0] b);
        string      tbl[$];
        logic [3:0] mm [0:N-1];
        int         idx, stop_at, a;
        byte        c, k, vch;
        logic [3:0] v, got;
        if (!m) tbl = '{"Uw0", "Ur0w1", "Ur1w0", "Dr0w1", "Dr1w0", "Ur0"};
        else    tbl = '{"Uw0", "Ur0w1", "Dr1w0"};
        e_we.delete(); e_addr.delete(); e_data.delete();
        e_fail = 0; e_cnt = 0; e_faddr = 0; e_felem = 0; e_fsyn = 0;
        idx = 0; stop_at = 1 << 30;
        for (int e = 0; e < tbl.size(); e++) begin
            c = tbl[e][0];
            for (int i = 0; i < N; i++) begin
                a = (c == "D") ? N - 1 - i : i;
                for (int p = 1; p < tbl[e].len(); p += 2) begin
                    if (idx <= stop_at) begin
                        k = tbl[e][p];
                        vch = tbl[e][p+1];
                        v = (vch == "1") ? ~b : b;
                        e_we.push_back(k == "w");
                        e_addr.push_back(a);
                        e_data.push_back(v);
                        if (k == "w") mm[a] = v;
                        else begin
                            got = faulty(a, mm[a]);
                            if (got != v) begin
                                if (!e_fail) begin
                                    e_faddr = a; e_felem = e; e_fsyn = int'(got ^ v);
                                end
                                e_fail = 1;
                                if (e_cnt < 255) e_cnt++;
                                if (sof && stop_at > idx) stop_at = idx + 1;
                            end
                        end
                        idx++;
                    end
                end
            end
        end
        n_ops = e_we.size();
    endtask

    task automatic run(input bit m, input bit sof, input logic [3:0] b, input bit hold);
        int op_err = 0, rd_err = 0, done_cyc = -1, hold_err = 0;
        model(m, sof, b);
        @(negedge clk);
        mode = m; stop_on_fail = sof; bg = b; start = 1'b1;
        for (int c = 1; c <= n_ops + 10; c++) begin
            @(posedge clk); #1;
            if (done) begin done_cyc = c; break; end
            if (!busy) op_err++;
            if (c <= n_ops) begin
                if (mem_we !== e_we[c-1] || int'(mem_addr) != e_addr[c-1]) op_err++;
                else if (mem_we && mem_wdata !== e_data[c-1]) op_err++;
            end else if (mem_we !== 1'b0) op_err++;
            if (func_rdata !== mem_rdata) rd_err++;
            if (!hold) start = 1'b0;
            func_we = 1'($urandom); func_addr = 8'($urandom); func_wdata = 4'($urandom);
        end
        func_we = 1'b0;
        chk("done_cycle", done_cyc, n_ops + 2);
        chk("op_stream", op_err, 0);
        chk("func_rdata", rd_err, 0);
        chk("busy_at_done", busy, 0);
        chk("pass", pass, !e_fail);
        chk("fail", fail, e_fail);
        chk("fail_cnt", fail_cnt, e_cnt);
        if (e_fail) begin
            chk("fail_addr", fail_addr, e_faddr);
            chk("fail_elem", fail_elem, e_felem);
            chk("fail_syn", fail_syn, e_fsyn);
        end
        if (hold) begin
            repeat (5) begin
                @(posedge clk); #1;
                if (!done || busy) hold_err++;
            end
            chk("no_rerun", hold_err, 0);
        end
        @(negedge clk) start = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", done, 0);
        chk("held_cnt", fail_cnt, e_cnt);
        chk("held_fail", fail, e_fail);
    endtask

    task automatic reset_test();
        fault_addr = -1; fault_all = 0;
        @(negedge clk);
        mode = 1'b0; stop_on_fail = 1'b0; bg = 4'h0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (499) @(posedge clk);
        #1 chk("busy_mid", busy, 1);
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_status", {done, pass, fail, fail_cnt, fail_addr, fail_elem, fail_syn}, 0);
        func_we = 1'b1; func_addr = 8'h10; func_wdata = 4'h5;
        #1 chk("rst_mux", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h10, 4'h5});
        @(posedge clk);
        @(negedge clk) rst = 1'b1; func_we = 1'b0;
        @(posedge clk); #1;
        chk("func_read", func_rdata, 4'h5);
        chk("post_rst_busy", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) sram[i] = 4'($urandom);
        #1;
        chk("reset_state", {busy, done, pass, fail, fail_cnt, fail_addr, fail_elem, fail_syn}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Clean March C- and MATS+
        run(0, 0, 4'h0, 0);
        chk("c_pass", pass | (fail_cnt != 0), 0);
        run(1, 0, 4'h0, 0);
        // Bit1 stuck-at-1 at 0x3A
        fault_addr = 'h3A; s1 = 4'b0010; s0 = '0;
        run(0, 0, 4'h0, 0);
        chk("sa1_cnt", fail_cnt, 3);
        chk("sa1_where", {fail_addr, fail_elem, fail_syn}, {8'h3A, 3'd1, 4'b0010});
        run(0, 1, 4'h0, 0);
        chk("sa1_stop_cnt", fail_cnt, 1);
        // Abort by reset mid-run
        reset_test();
        // Checkerboard-style background, start held through DONE
        fault_addr = -1; s1 = '0;
        run(0, 0, 4'b1010, 1);
        // Every address faulty: count saturates
        fault_all = 1; s1 = 4'b0001;
        run(1, 0, 4'h0, 0);
        chk("sat_cnt", fail_cnt, 255);
        fault_all = 0; s1 = '0;
        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            fault_addr = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, N - 1));
            s1 = '0; s0 = '0;
            if ($urandom & 1) s1 = 4'(1 << $urandom_range(0, 3));
            else              s0 = 4'(1 << $urandom_range(0, 3));
            run(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/march_bist.md
MARCH_BIST -- requirements
Module: march_bist

Interface
REQ-001 SHALL have parameter DATA_W, default 4, SRAM word width.
REQ-002 SHALL have parameter ADDR_W, default 8, SRAM address width; depth N = 2**ADDR_W.
REQ-003 SHALL have parameter CNT_W, default 8, fail counter width.
REQ-004 SHALL have ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: start in 1, run request; mode in 1, 0=March C-, 1=MATS+; stop_on_fail in 1, halt at first miscompare; bg in DATA_W, data background.
REQ-006 SHALL have functional ports: func_we in 1; func_addr in ADDR_W; func_wdata in DATA_W; func_rdata out DATA_W.
REQ-007 SHALL have memory ports: mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, valid one cycle after address.
REQ-008 SHALL have status ports: busy out 1; done out 1; pass out 1; fail out 1; fail_addr out ADDR_W; fail_elem out 3; fail_syn out DATA_W; fail_cnt out CNT_W.

Function
REQ-009 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-010 IDLE: start=1 SHALL latch mode, stop_on_fail, bg; clear fail, fail_cnt, fail_addr, fail_elem, fail_syn; go RUN.
REQ-011 March C- SHALL be elements 0..5: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0).
REQ-012 MATS+ SHALL be elements 0..2: up(w0); up(r0,w1); down(r1,w0).
REQ-013 Value "0" SHALL be latched bg; "1" SHALL be ~bg.
REQ-014 RUN SHALL issue exactly one memory operation per cycle; "up" = address 0..N-1, "down" = N-1..0; all ops of an element at one address before advancing.
REQ-015 Total ops SHALL be 10N (March C-) or 5N (MATS+).
REQ-016 Each read SHALL register expected value, address, element index; compare against mem_rdata the following cycle.
REQ-017 Miscompare SHALL set fail sticky, increment fail_cnt saturating at 2**CNT_W-1.
REQ-018 First miscompare only SHALL capture fail_addr, fail_elem, fail_syn = expected XOR mem_rdata.
REQ-019 stop_on_fail=1 and miscompare SHALL stop issuing ops next cycle and go DRAIN.
REQ-020 After last op, RUN SHALL go DRAIN for one cycle (final compare), then DONE.
REQ-021 Latency: start sampled cycle 0, first op cycle 1, done=1 in cycle 10N+2 (March C-) / 5N+2 (MATS+) with no stop.
REQ-022 busy SHALL be 1 in RUN and DRAIN; done SHALL be 1 only in DONE; pass = done & ~fail.
REQ-023 DONE SHALL hold until start=0, then IDLE; start while busy SHALL be ignored.
REQ-024 While busy=0, mem_we/mem_addr/mem_wdata SHALL equal func_we/func_addr/func_wdata combinationally; while busy=1, func_we SHALL be ignored.
REQ-025 func_rdata SHALL equal mem_rdata at all times.
REQ-026 Status outputs SHALL hold values from DONE through IDLE until next accepted start.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE; busy, done, pass, fail, fail_cnt, fail_addr, fail_elem, fail_syn, internal counters = 0.
REQ-028 Reset mid-run SHALL abort immediately; mem path returns to functional ports; no further BIST writes.

Verification
REQ-029 Clean RAM, DATA_W=4, ADDR_W=8, mode=0, bg=0 -> done in cycle 2562, pass=1, fail_cnt=0.
REQ-030 Same, mode=1 -> done in cycle 1282, pass=1; address order up,up,down checked per element.
REQ-031 Bit1 stuck-at-1 at 0x3A, mode=0, stop_on_fail=0 -> fail=1, fail_addr=0x3A, fail_elem=1, fail_syn=4'b0010, fail_cnt=3.
REQ-032 Same fault, stop_on_fail=1 -> no mem op after the compare cycle, done within 3 cycles of miscompare, fail_cnt=1.
REQ-033 rst=0 at cycle 500 of run -> busy=0 same cycle, all status 0; func write 0x5 to 0x10 then read returns 0x5.
REQ-034 bg=4'b1010, mode=0, clean -> writes alternate 0xA/0x5 per element, pass=1; start held through DONE gives no rerun.
